uart_tx_burst: RTL

UART_TX_BURST -- requirements
Module: uart_tx_burst

---
 rtl/uart_tx_burst_if.sv | 31 +++
 rtl/uart_tx_burst.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_burst_if.sv
//------------------------------------------------------------------------------
// uart_tx_burst_if
// Frame-load handshake and serial-line status bundle for uart_tx_burst.
//   i_Frame_DV     frame load request (from master)
//   i_Frame_Data   8-byte frame, byte 0 in bits [7:0] (from master)
//   o_Frame_Ready  transmitter idle and able to accept a frame
//   o_Tx_Serial    UART serial line, idle high
//   o_Tx_Active    a frame bit is currently on the line
//   o_Byte_Index   index of the byte currently being sent
//   o_Frame_Done   one-cycle pulse after the last stop bit of byte 7
// Modports: master = frame source, slave = transmitter.
//------------------------------------------------------------------------------
interface uart_tx_burst_if;
    logic        i_Frame_DV;
    logic [63:0] i_Frame_Data;
    logic        o_Frame_Ready;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic [2:0]  o_Byte_Index;
    logic        o_Frame_Done;

    modport master (
        output i_Frame_DV, i_Frame_Data,
        input  o_Frame_Ready, o_Tx_Serial, o_Tx_Active, o_Byte_Index, o_Frame_Done
    );

    modport slave (
        input  i_Frame_DV, i_Frame_Data,
        output o_Frame_Ready, o_Tx_Serial, o_Tx_Active, o_Byte_Index, o_Frame_Done
    );
endinterface

// File: rtl/uart_tx_burst.sv
//------------------------------------------------------------------------------
// uart_tx_burst
// Sends an 8-byte frame as eight back-to-back UART characters, byte 0 first,
// LSB first, 8N1 by default. Defining UART_TX_BURST_PARITY_EN inserts an
// even-parity bit after the data bits of every byte (8E1).
// Parameter:
//   CLKS_PER_BIT  i_Clock cycles per serial bit (2..65535)
// Ports:
//   i_Clock   single clock
//   i_Reset   asynchronous, active-high reset
//   io_Bus    uart_tx_burst_if.slave (frame handshake + serial line status)
// All outputs come straight from flops; next output values are decoded from
// the next state so they line up with the state they describe.
//------------------------------------------------------------------------------
module uart_tx_burst #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    uart_tx_burst_if.slave  io_Bus
);

    localparam logic [15:0] LP_BIT_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_BURST_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

    state_t      r_state,     w_state_d;
    logic [15:0] r_clk_cnt,   w_clk_cnt_d;
    logic [2:0]  r_bit_cnt,   w_bit_cnt_d;
    logic [2:0]  r_byte_idx,  w_byte_idx_d;
    logic [63:0] r_frame,     w_frame_d;   // current byte always in [7:0]
    logic        r_tx_serial, w_tx_serial_d;
    logic        r_tx_active, w_tx_active_d;
    logic        r_ready,     w_ready_d;
    logic        r_done,      w_done_d;

    logic        w_bit_end;
    logic        w_accept;
    logic [7:0]  w_next_byte;

    assign w_bit_end   = (r_clk_cnt == LP_BIT_LAST);
    // r_ready is low for the first cycle after reset, so acceptance waits too.
    assign w_accept    = (r_state == IDLE) && r_ready && io_Bus.i_Frame_DV;
    assign w_next_byte = w_frame_d[7:0];

    //--------------------------------------------------------------------------
    // State and datapath register
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_byte_idx  <= '0;
            r_frame     <= '0;
            r_tx_serial <= 1'b1;
            r_tx_active <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_clk_cnt   <= w_clk_cnt_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_byte_idx  <= w_byte_idx_d;
            r_frame     <= w_frame_d;
            r_tx_serial <= w_tx_serial_d;
            r_tx_active <= w_tx_active_d;
            r_ready     <= w_ready_d;
            r_done      <= w_done_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and datapath logic
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_d    = r_state;
        w_clk_cnt_d  = r_clk_cnt;
        w_bit_cnt_d  = r_bit_cnt;
        w_byte_idx_d = r_byte_idx;
        w_frame_d    = r_frame;

        // Bit timer runs in every line state and wraps at the end of each bit.
        if ((r_state != IDLE) && (r_state != DONE)) begin
            w_clk_cnt_d = w_bit_end ? '0 : r_clk_cnt + 16'd1;
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_d    = START;
                    w_frame_d    = io_Bus.i_Frame_Data;
                    w_byte_idx_d = '0;
                    w_clk_cnt_d  = '0;
                    w_bit_cnt_d  = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_d   = DATA;
                    w_bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_BURST_PARITY_EN
                        w_state_d = PARITY;
`else
                        w_state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_BURST_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    if (r_byte_idx == 3'd7) begin
                        w_state_d = DONE;
                    end else begin
                        // Next byte follows immediately: no idle gap.
                        w_state_d    = START;
                        w_byte_idx_d = r_byte_idx + 3'd1;
                        w_frame_d    = {8'h00, r_frame[63:8]};
                    end
                end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Output decode (from next state, registered above)
    //--------------------------------------------------------------------------
    always_comb begin
        w_tx_serial_d = 1'b1;
        w_tx_active_d = 1'b0;
        w_ready_d     = 1'b0;
        w_done_d      = 1'b0;

        case (w_state_d)
            IDLE:  w_ready_d = 1'b1;
            START: begin
                w_tx_serial_d = 1'b0;
                w_tx_active_d = 1'b1;
            end
            DATA: begin
                w_tx_serial_d = w_next_byte[w_bit_cnt_d];
                w_tx_active_d = 1'b1;
            end
`ifdef UART_TX_BURST_PARITY_EN
            PARITY: begin
                w_tx_serial_d = ^w_next_byte;  // even parity
                w_tx_active_d = 1'b1;
            end
`endif
            STOP:    w_tx_active_d = 1'b1;
            DONE:    w_done_d      = 1'b1;
            default: w_ready_d     = 1'b0;
        endcase
    end

    assign io_Bus.o_Frame_Ready = r_ready;
    assign io_Bus.o_Tx_Serial   = r_tx_serial;
    assign io_Bus.o_Tx_Active   = r_tx_active;
    assign io_Bus.o_Byte_Index  = r_byte_idx;
    assign io_Bus.o_Frame_Done  = r_done;

endmodule
